// File: rtl/panda_clocks_if.sv
// panda_clocks_if: period registers in, generated clocks out.
//   CLOCKx_PERIOD : 32-bit period in system clock ticks (x = A..D)
//   clockx_o      : generated square wave for channel x
// The master modport drives the periods. The slave modport (panda_clocks) drives the clocks.
interface panda_clocks_if;
  logic [31:0] CLOCKA_PERIOD;
  logic [31:0] CLOCKB_PERIOD;
  logic [31:0] CLOCKC_PERIOD;
  logic [31:0] CLOCKD_PERIOD;
  logic        clocka_o;
  logic        clockb_o;
  logic        clockc_o;
  logic        clockd_o;

  modport master (
    output CLOCKA_PERIOD, CLOCKB_PERIOD, CLOCKC_PERIOD, CLOCKD_PERIOD,
    input  clocka_o, clockb_o, clockc_o, clockd_o
  );

  modport slave (
    input  CLOCKA_PERIOD, CLOCKB_PERIOD, CLOCKC_PERIOD, CLOCKD_PERIOD,
    output clocka_o, clockb_o, clockc_o, clockd_o
  );
endinterface

// File: rtl/panda_clocks.sv
// panda_clocks: four independent programmable square-wave generators.
//   clk_i   : system clock, rising edge
//   reset_i : synchronous active-low reset
//   bus     : panda_clocks_if.slave (four periods in, four registered clocks out)
// Each channel is high for floor(P/2) ticks and then low for the remaining ticks.
// A period of 0 or 1 holds the output low.

// One generator channel.
//   clk, rst_n : clock and synchronous active-low reset
//   period     : requested period in ticks
//   out        : registered square wave
module panda_clocks_chan (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] period,
  output logic        out
);
  logic [31:0] cnt;
  logic [31:0] per_q;
  logic [31:0] half;

  assign half = per_q >> 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      out   <= 1'b0;
      per_q <= period;
    end else if (period != per_q) begin
      // A new period restarts the phase. The first high comes on the next edge.
      per_q <= period;
      cnt   <= '0;
      out   <= 1'b0;
    end else if (per_q < 32'd2) begin
      cnt <= '0;
      out <= 1'b0;
    end else begin
      out <= (cnt < half);
      cnt <= (cnt == per_q - 32'd1) ? '0 : cnt + 32'd1;
    end
  end
endmodule

module panda_clocks (
  input  logic           clk_i,
  input  logic           reset_i,
  panda_clocks_if.slave  bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][31:0] per;
  logic [NUM_LANES-1:0]       clk_out;

  assign per = {bus.CLOCKD_PERIOD, bus.CLOCKC_PERIOD,
                bus.CLOCKB_PERIOD, bus.CLOCKA_PERIOD};

  panda_clocks_chan u_chan [NUM_LANES-1:0] (
    .clk   (clk_i),
    .rst_n (reset_i),
    .period(per),
    .out   (clk_out)
  );

  assign bus.clocka_o = clk_out[0];
  assign bus.clockb_o = clk_out[1];
  assign bus.clockc_o = clk_out[2];
  assign bus.clockd_o = clk_out[3];
endmodule

// File: tb/tb_panda_clocks.sv
module tb_panda_clocks;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  panda_clocks_if bus ();

  panda_clocks dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  logic [31:0] per_in [4];
  assign bus.CLOCKA_PERIOD = per_in[0];
  assign bus.CLOCKB_PERIOD = per_in[1];
  assign bus.CLOCKC_PERIOD = per_in[2];
  assign bus.CLOCKD_PERIOD = per_in[3];

  int checks = 0;
  int errors = 0;

  logic [3:0]     exp_q [$];
  logic [31:0]    m_per [4];
  longint         m_t   [4];
  logic [3:0]     last_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // The reference model works from the elapsed ticks since the phase started.
  // It uses a modulo, not a wrapping counter.
  task automatic step(input string tag);
    logic [3:0] e;
    logic [3:0] got;
    logic [3:0] ex;
    for (int i = 0; i < 4; i++) begin
      if (!reset || per_in[i] != m_per[i]) begin
        m_per[i] = per_in[i];
        m_t[i]   = 0;
        e[i]     = 1'b0;
      end else if (m_per[i] < 2) begin
        m_t[i] = 0;
        e[i]   = 1'b0;
      end else begin
        e[i] = ((m_t[i] % longint'(m_per[i])) < longint'(m_per[i] / 2));
        m_t[i]++;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {bus.clockd_o, bus.clockc_o, bus.clockb_o, bus.clocka_o};
    ex  = exp_q.pop_front();
    last_exp = ex;
    chk(tag, {28'd0, got}, {28'd0, ex});
  endtask

  initial begin
    int n_high;
    for (int i = 0; i < 4; i++) begin
      m_per[i] = '0;
      m_t[i]   = 0;
    end

    // Basic run.
    per_in[0] = 32'd4; per_in[1] = 32'd5; per_in[2] = 32'd2; per_in[3] = 32'd100;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step("reset");
    reset = 1'b1;
    for (int k = 0; k < 200; k++) step("basic");

    // Change the period while A is high.
    for (int k = 0; k < 8 && bus.clocka_o !== 1'b1; k++) step("wait_a_high");
    chk("a_high_before_change", {31'd0, bus.clocka_o}, 32'd1);
    per_in[0] = 32'd6;
    for (int k = 0; k < 60; k++) step("period_change");

    // Pulse reset mid-operation.
    reset = 1'b0;
    step("mid_reset");
    reset = 1'b1;
    for (int k = 0; k < 120; k++) step("after_reset");

    // Disabled channels.
    per_in[0] = 32'd0; per_in[1] = 32'd1; per_in[2] = 32'd3;
    for (int k = 0; k < 30; k++) step("disabled");

    // Odd and even boundary periods, 20 periods of A.
    per_in[0] = 32'd3; per_in[1] = 32'd2;
    for (int k = 0; k < 61; k++) step("odd_even");

    // Maximum period keeps D high.
    per_in[3] = 32'hFFFF_FFFF;
    for (int k = 0; k < 1100; k++) step("d_max");

    // With D = 2^16, D is high for exactly 32768 ticks.
    per_in[3] = 32'h0001_0000;
    n_high = 0;
    for (int k = 0; k < 33000; k++) begin
      step("d_64k");
      if (bus.clockd_o === 1'b1) n_high++;
    end
    chk("d_high_ticks", n_high, 32'd32768);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
